// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types for the IF/LS memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_addr_w = 32;
    localparam int c_data_w = 32;
    localparam int c_be_w   = c_data_w / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    typedef struct packed {
        logic [c_addr_w-1:0] addr;
        logic                we;
        logic [c_data_w-1:0] wdata;
        logic [c_be_w-1:0]   be;
    } mem_req_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_prio
// Purpose  : Fixed LS priority with a starvation guard for IF; owns the
//            saturating count of LS grants taken while IF was waiting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_prio #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic arstn,
    input  logic arb_en,
    input  logic if_valid,
    input  logic ls_valid,
    output logic grant_if,
    output logic grant_ls
);

    localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_if_starved;

    // LS wins unless IF has already been passed over STARVE_MAX times
    always_comb begin
        w_if_starved = if_valid && (r_starve_cnt == c_starve_limit);
        grant_ls     = arb_en && ls_valid && !w_if_starved;
        grant_if     = arb_en && if_valid && !grant_ls;
    end

    // Count LS wins over a waiting IF; an IF win clears the count
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_starve_cnt <= '0;
        end else if (grant_if) begin
            r_starve_cnt <= '0;
        end else if (grant_ls && if_valid && (r_starve_cnt != c_starve_limit)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule : mem_arb_prio
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between instruction fetch (IF) and the
//            load/store unit (LS); one transaction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_we,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_be,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    state_t r_state;
    state_t w_next_state;
    owner_t r_owner;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;

    logic w_arb_en;
    logic w_grant_if;
    logic w_grant_ls;
    logic w_grant;

    // Readies must read 0 while reset is held, so reset also gates arbitration
    assign w_arb_en = (r_state == IDLE) && arstn;
    assign w_grant  = w_grant_if || w_grant_ls;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (4)
    ) u_prio (
        .clk      (clk),
        .arstn    (arstn),
        .arb_en   (w_arb_en),
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .grant_if (w_grant_if),
        .grant_ls (w_grant_ls)
    );

    // FSM state register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, handshakes and response routing to the current owner
    always_comb begin
        w_next_state  = r_state;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        if_rsp_valid  = 1'b0;
        ls_rsp_valid  = 1'b0;
        if_rsp_data   = '0;
        ls_rsp_data   = '0;
        case (r_state)
            IDLE: begin
                if_req_ready = w_grant_if;
                ls_req_ready = w_grant_ls;
                if (w_grant) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (r_owner == OWN_LS) begin
                    ls_rsp_valid = mem_rsp_valid;
                    ls_rsp_data  = mem_rsp_data;
                end else begin
                    if_rsp_valid = mem_rsp_valid;
                    if_rsp_data  = mem_rsp_data;
                end
                if (mem_rsp_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the winning request; IF fetches are always full-width reads
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_grant_ls) begin
            r_owner <= OWN_LS;
            r_addr  <= ls_req_addr;
            r_we    <= ls_req_we;
            r_wdata <= ls_req_wdata;
            r_be    <= ls_req_be;
        end else if (w_grant_if) begin
            r_owner <= OWN_IF;
            r_addr  <= if_req_addr;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '1;
        end
    end

    assign mem_req_addr  = r_addr;
    assign mem_req_we    = r_we;
    assign mem_req_wdata = r_wdata;
    assign mem_req_be    = r_be;

endmodule : mem_arbiter
`default_nettype wire
